// File: rtl/alu_op_sequencer.sv
// ALU control sequencer: decodes ir[31:27] into one-hot ALU strobes, holds them for the
// operation's cycle count, then captures the 64-bit result. Optional macro: ALU_SEQ_PERF_EN.
module alu_op_sequencer #(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              start,
  input  logic              inc_req,
  input  logic [DATA_W-1:0] ir,
  input  logic [DATA_W-1:0] alu_hi,
  input  logic [DATA_W-1:0] alu_lo,
  output logic [13:0]       alu_ctl,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [DATA_W-1:0] z_hi,
  output logic [DATA_W-1:0] z_lo,
  output logic              hi_we,
  output logic              lo_we,
  output logic              z_we
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [31:0]       op_count
`endif
);

  localparam int CTL_ADD  = 0;
  localparam int CTL_SUB  = 1;
  localparam int CTL_MUL  = 2;
  localparam int CTL_DIV  = 3;
  localparam int CTL_AND  = 4;
  localparam int CTL_OR   = 5;
  localparam int CTL_SHR  = 6;
  localparam int CTL_SHRA = 7;
  localparam int CTL_SHL  = 8;
  localparam int CTL_ROR  = 9;
  localparam int CTL_ROL  = 10;
  localparam int CTL_NEG  = 11;
  localparam int CTL_NOT  = 12;
  localparam int CTL_INC  = 13;

  // Counter is loaded with N-1 so EXEC lasts exactly N cycles.
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [13:0]         ctl_reg, ctl_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                illegal_reg, illegal_next;
  logic [DATA_W-1:0]   z_hi_reg, z_hi_next;
  logic [DATA_W-1:0]   z_lo_reg, z_lo_next;

  logic [4:0]          opcode;
  logic [13:0]         dec_ctl;
  logic [3:0]          dec_load;
  logic                dec_legal;
  logic                exec_active;
  logic                muldiv;
  logic                unused_ir;

  assign opcode    = ir[DATA_W-1 -: 5];
  assign unused_ir = ^ir[DATA_W-6:0];

  always_comb begin
    dec_ctl  = '0;
    dec_load = 4'd0;
    case (opcode)
      5'b00011: dec_ctl[CTL_ADD]  = 1'b1;
      5'b00100: dec_ctl[CTL_SUB]  = 1'b1;
      5'b00101: dec_ctl[CTL_SHR]  = 1'b1;
      5'b00110: dec_ctl[CTL_SHRA] = 1'b1;
      5'b00111: dec_ctl[CTL_SHL]  = 1'b1;
      5'b01000: dec_ctl[CTL_ROR]  = 1'b1;
      5'b01001: dec_ctl[CTL_ROL]  = 1'b1;
      5'b01010: dec_ctl[CTL_AND]  = 1'b1;
      5'b01011: dec_ctl[CTL_OR]   = 1'b1;
      5'b01111: begin
        dec_ctl[CTL_MUL] = 1'b1;
        dec_load         = MUL_LOAD;
      end
      5'b10000: begin
        dec_ctl[CTL_DIV] = 1'b1;
        dec_load         = DIV_LOAD;
      end
      5'b10001: dec_ctl[CTL_NEG]  = 1'b1;
      5'b10010: dec_ctl[CTL_NOT]  = 1'b1;
      default:  dec_ctl = '0;
    endcase
  end

  assign dec_legal = |dec_ctl;

  always_comb begin
    state_next   = state_reg;
    ctl_next     = ctl_reg;
    cnt_next     = cnt_reg;
    illegal_next = illegal_reg;
    z_hi_next    = z_hi_reg;
    z_lo_next    = z_lo_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          ctl_next     = dec_ctl;
          cnt_next     = dec_load;
          illegal_next = ~dec_legal;
          state_next   = dec_legal ? EXEC : DONE;
        end else if (inc_req) begin
          ctl_next          = '0;
          ctl_next[CTL_INC] = 1'b1;
          cnt_next          = 4'd0;
          illegal_next      = 1'b0;
          state_next        = EXEC;
        end
      end
      EXEC: begin
        if (cnt_reg == 4'd0) begin
          z_hi_next  = alu_hi;
          z_lo_next  = alu_lo;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_reg   <= IDLE;
      ctl_reg     <= '0;
      cnt_reg     <= 4'd0;
      illegal_reg <= 1'b0;
      z_hi_reg    <= '0;
      z_lo_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      ctl_reg     <= ctl_next;
      cnt_reg     <= cnt_next;
      illegal_reg <= illegal_next;
      z_hi_reg    <= z_hi_next;
      z_lo_reg    <= z_lo_next;
    end
  end

  // Strobes are gated by state so IDLE/DONE always show zero regardless of ctl_reg.
  assign exec_active = (state_reg == EXEC);
  generate
    for (genvar gi = 0; gi < 14; gi++) begin : g_ctl
      assign alu_ctl[gi] = exec_active & ctl_reg[gi];
    end
  endgenerate

  assign muldiv  = ctl_reg[CTL_MUL] | ctl_reg[CTL_DIV];
  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign illegal = done & illegal_reg;
  assign hi_we   = done & ~illegal_reg & muldiv;
  assign lo_we   = done & ~illegal_reg & muldiv;
  assign z_we    = done & ~illegal_reg & ~muldiv;
  assign z_hi    = z_hi_reg;
  assign z_lo    = z_lo_reg;

`ifdef ALU_SEQ_PERF_EN
  logic [31:0] op_count_reg;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      op_count_reg <= '0;
    end else if (done && !illegal_reg && (op_count_reg != 32'hFFFF_FFFF)) begin
      op_count_reg <= op_count_reg + 32'd1;
    end
  end

  assign op_count = op_count_reg;
`endif

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Control-side counterpart of the datapath ALU.
- Decodes the 5-bit opcode in an instruction word into the ALU's one-hot operation strobes.
- Holds each strobe for the operation's required number of cycles, then captures the ALU's 64-bit result (Chigh/Clow) into the Z register pair.
- Issues write enables to HI/LO for MUL/DIV, or to Z-low for all other operations.

Parameters:
- DATA_W, 32, width of each ALU result half and of the instruction word.
- MUL_CYCLES, 2, cycles MUL strobe is held before result capture (legal range 1..15).
- DIV_CYCLES, 4, cycles DIV strobe is held before result capture (legal range 1..15).

Ports:
- clock  in  1  system clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- start  in  1  request: decode ir and execute; sampled only in IDLE.
- inc_req  in  1  request a single PC-increment operation; sampled only in IDLE, lower priority than start.
- ir  in  DATA_W  instruction word; opcode = ir[31:27].
- alu_hi  in  DATA_W  ALU Chigh result.
- alu_lo  in  DATA_W  ALU Clow result.
- alu_ctl  out  14  one-hot ALU strobes. Bit order from bit0: ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, IncPC.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  one-cycle pulse, coincident with done, for an undefined opcode.
- z_hi  out  DATA_W  captured alu_hi.
- z_lo  out  DATA_W  captured alu_lo.
- hi_we  out  1  write HI (MUL/DIV only), pulses with done.
- lo_we  out  1  write LO (MUL/DIV only), pulses with done.
- z_we  out  1  write Z-low (all other legal ops, including IncPC), pulses with done.

Behaviour:
- Clocking and reset: single clock; clear_n is asynchronous, active-low. Asserting clear_n (including mid-operation) forces:
  - state to IDLE;
  - all outputs to 0, including z_hi, z_lo and the cycle counter.
- Opcode map (binary):
  - ADD 00011, SUB 00100, SHR 00101, SHRA 00110, SHL 00111;
  - ROR 01000, ROL 01001, AND 01010, OR 01011;
  - MUL 01111, DIV 10000, NEG 10001, NOT 10010;
  - every other value is illegal.
- States: IDLE, EXEC, DONE.
- IDLE:
  - start=1: latch opcode. Legal opcode goes to EXEC; illegal opcode goes directly to DONE with illegal pending.
  - else inc_req=1: select IncPC and go to EXEC.
  - start and inc_req both high: start wins, inc_req is dropped (not queued).
- EXEC:
  - Exactly one alu_ctl bit is high, constant for N cycles: N = MUL_CYCLES for MUL, DIV_CYCLES for DIV, 1 otherwise.
  - A 4-bit counter loads N-1 on entry and decrements each cycle.
  - At the clock edge ending the last EXEC cycle, alu_hi/alu_lo are registered into z_hi/z_lo; state goes to DONE.
- DONE, one cycle:
  - done=1.
  - Write enable: hi_we and lo_we for MUL/DIV; z_we for other legal ops; no write enable for an illegal op.
  - alu_ctl is all zero.
  - Returns to IDLE; a new start can be sampled on the edge ending DONE only if state is IDLE, so the earliest next acceptance is the cycle after DONE.
- Latency, start sampled at edge 0:
  - single-cycle op: EXEC in cycle 1, done in cycle 2;
  - MUL: done in cycle MUL_CYCLES+1;
  - illegal opcode: done+illegal in cycle 1.
- Other rules:
  - start/inc_req asserted while busy is ignored.
  - ir changes after acceptance have no effect (opcode is latched).
  - z_hi/z_lo hold their value until the next capture; an illegal opcode does not update them.
  - alu_ctl is never multi-hot; in IDLE it is all zero.

Optional Feature:
- Macro: ALU_SEQ_PERF_EN.
- When defined: adds output op_count (32 bits), reset to 0. It increments on every done pulse with illegal=0 and saturates at 32'hFFFFFFFF.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-MUL: assert clear_n=0 in the second EXEC cycle -> same cycle, alu_ctl=0, busy=0, z_hi=z_lo=0; next start is accepted normally.
- ADD: ir[31:27]=00011, start one cycle, alu_lo=32'h0000_0007 -> alu_ctl=14'h0001 for 1 cycle; then done=1, z_we=1, z_lo=7.
- MUL (MUL_CYCLES=2): ir[31:27]=01111, alu_hi=32'h1, alu_lo=32'hFFFF_FFFE -> alu_ctl=14'h0004 for 2 cycles; done at cycle 3 with hi_we=lo_we=1, z_hi=1, z_lo=FFFF_FFFE.
- Illegal opcode 11111 -> done=illegal=1 at cycle 1; no write enable; alu_ctl never nonzero; z unchanged.
- start and inc_req together with OR opcode 01011 -> alu_ctl=14'h0020, IncPC never issued; a start pulse during EXEC is ignored.
- inc_req alone with alu_lo=32'h0000_0011 -> alu_ctl=14'h2000 for 1 cycle; z_we=1, z_lo=32'h11; with ALU_SEQ_PERF_EN, op_count increments by 1.
